// File: rtl/sofa_plus_scan_ctrl.sv
// Scan-chain sequencer: serialises host words onto a shared-pin flop chain,
// packs the chain tail into host words, and optionally fires one capture clock.
module sofa_plus_scan_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic              capture_req,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  output logic              cap_valid,
  output logic [WORD_W-1:0] cap_data,
  input  logic              cap_ready,
  output logic              sc_en,
  output logic              sc_di,
  input  logic              sc_do,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);
  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int SW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CAPT = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg, acc, acc_nxt;
  logic [SW-1:0]     sbits, abits, load_bits;
  logic [RW-1:0]     rem;
  logic              cap_flag, shift, load_take, word_full;
  int                avail;

  // Both host streams are valid/ready: a word moves on an edge where valid and
  // ready are both high; cap_valid holds with cap_data stable until taken.
  assign shift      = (state == SHIFT) && (sbits != '0) && !(cap_valid && !cap_ready);
  assign load_ready = (state == SHIFT) && (int'(rem) > int'(sbits)) &&
                      ((sbits == '0) || ((sbits == SW'(1)) && shift));
  assign load_take  = load_ready && load_valid;

  // Bits of rem not already held in sreg decide how much of the new word counts.
  always_comb begin
    avail     = int'(rem) - int'(sbits);
    load_bits = (avail > WORD_W) ? SW'(WORD_W) : SW'(avail);
  end

  assign acc_nxt   = acc | (WORD_W'(sc_do) << abits);
  assign word_full = (int'(abits) == WORD_W - 1) || (rem == RW'(1));

  always_ff @(posedge C) begin
    if (!R) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: if ((rem == '0) && (!cap_valid || cap_ready))
               state_nxt = cap_flag ? CAPT : DONE;
      CAPT:  state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    sc_en        = 1'b0;
    sc_di        = 1'b0;
    chain_clk_en = 1'b0;
    done         = 1'b0;
    case (state)
      SHIFT: begin
        sc_en        = 1'b1;
        sc_di        = sreg[0];
        chain_clk_en = shift;
      end
      CAPT:  chain_clk_en = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge C) begin
    if (!R) begin
      sreg      <= '0;
      sbits     <= '0;
      rem       <= '0;
      acc       <= '0;
      abits     <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
      cap_flag  <= 1'b0;
    end else if (abort) begin
      cap_valid <= 1'b0;
      acc       <= '0;
      abits     <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        rem      <= RW'(CHAIN_LEN);
        sbits    <= '0;
        abits    <= '0;
        acc      <= '0;
        cap_flag <= capture_req;
      end
      if (cap_valid && cap_ready) cap_valid <= 1'b0;
      if (shift) begin
        sreg  <= sreg >> 1;
        sbits <= sbits - SW'(1);
        rem   <= rem - RW'(1);
        // A fresh emission wins over the clear of the word just taken.
        if (word_full) begin
          cap_data  <= acc_nxt;
          cap_valid <= 1'b1;
          acc       <= '0;
          abits     <= '0;
        end else begin
          acc   <= acc_nxt;
          abits <= abits + SW'(1);
        end
      end
      if (load_take) begin
        sreg  <= load_data;
        sbits <= load_bits;
      end
    end
  end
endmodule

// File: tb/tb_sofa_plus_scan_ctrl.sv
// Bench for sofa_plus_scan_ctrl: 12-flop chain model, table of shift
// scenarios, hand sequences for abort/reset, and randomized handshakes.
module tb_sofa_plus_scan_ctrl;
  localparam int          CL     = 12;
  localparam int          WW     = 8;
  localparam logic [11:0] FUNC_D = 12'h5C3;

  logic        C = 1'b0, R = 1'b0;
  logic        start = 1'b0, capture_req = 1'b0, abort = 1'b0;
  logic        load_valid = 1'b0, cap_ready = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready, cap_valid, sc_en, sc_di, chain_clk_en, busy, done;
  logic [7:0]  cap_data;
  logic [1:0]  fsm_state;
  logic [11:0] chain = '0;

  int          total = 0, bad = 0;
  logic [WW-1:0] exp_q[$];

  typedef struct {
    logic [11:0] pre;
    logic [7:0]  w0, w1;
    logic        capq;
    int          gap, stall;
    logic [11:0] exp_chain;
    logic [7:0]  exp_c0, exp_c1;
    int          exp_lat, exp_clk;
  } vec_t;

  always #5 C = ~C;

  sofa_plus_scan_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .C(C), .R(R), .start(start), .capture_req(capture_req), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .sc_en(sc_en), .sc_di(sc_di), .sc_do(chain[0]), .chain_clk_en(chain_clk_en),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sc_en"}, sc_en, 0);
    check({tag, "_clk_en"}, chain_clk_en, 0);
    check({tag, "_cap_valid"}, cap_valid, 0);
    check({tag, "_load_ready"}, load_ready, 0);
    check({tag, "_sc_di"}, sc_di, 0);
  endtask

  // One full start..done operation; the chain model shifts tail-first.
  task automatic run_op(input logic [11:0] pre, input logic [7:0] w0, input logic [7:0] w1,
                        input logic capq, input int gap, input int stall, input bit rnd,
                        output int lat, output int clks, output int got_n);
    logic [7:0] words [2];
    int  widx, gap_left, stall_left, last_shift, capt_cyc, capts;
    bit  gap_armed, stall_armed;
    logic en, sen, di, lr, cv, dn;
    logic [7:0] cd;
    words[0] = w0; words[1] = w1;
    widx = 0; gap_left = 0; stall_left = 0; gap_armed = 1; stall_armed = 1;
    last_shift = -1; capt_cyc = -1; capts = 0;
    chain = pre; lat = -1; clks = 0; got_n = 0;
    @(negedge C);
    start = 1'b1; capture_req = capq; load_valid = 1'b0; cap_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && lat < 0; cyc++) begin
      if (cyc > 0) begin
        @(negedge C);
        start = 1'b0; capture_req = 1'b0;
        if (cap_valid && stall_armed && stall > 0) begin
          stall_left = stall; stall_armed = 0;
        end
        if (stall_left > 0) begin
          cap_ready = 1'b0; stall_left--;
        end else begin
          cap_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        #1;
        if (widx == 1 && load_ready && gap_armed && gap > 0) begin
          gap_left = gap; gap_armed = 0;
        end
        if (gap_left > 0) begin
          load_valid = 1'b0; gap_left--;
        end else begin
          load_valid = (widx < 2) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
        if (widx < 2) load_data = words[widx];
      end
      #1;
      en = chain_clk_en; sen = sc_en; di = sc_di; lr = load_ready;
      cv = cap_valid; cd = cap_data; dn = done;
      if (cv && !cap_ready) check("stall_freeze", en, 0);
      if (dn) lat = cyc;
      if (cv && cap_ready) begin
        got_n++;
        if (exp_q.size() > 0) check("cap_word", cd, exp_q.pop_front());
      end
      @(posedge C);
      #1;
      if (lr && load_valid) widx++;
      if (en) begin
        clks++;
        if (sen) begin
          chain = {di, chain[11:1]};
          last_shift = cyc;
        end else begin
          chain = FUNC_D;
          capts++;
          capt_cyc = cyc;
        end
      end
    end
    load_valid = 1'b0;
    check("done_seen", lat >= 0, 1);
    check("capture_count", capts, capq);
    if (capq) begin
      check("capture_before_done", capt_cyc + 1, lat);
      check("capture_after_shift", capt_cyc > last_shift, 1);
    end
    @(negedge C);
    #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    vec_t vecs [5];
    int lat, clks, got_n, n, dcount;
    logic [11:0] pre, exp_chain;
    logic [7:0] w0, w1;
    logic capq;

    vecs[0] = '{12'hABC, 8'hA5, 8'h03, 1'b0, 0, 0, 12'h3A5, 8'hBC, 8'h0A, 15, 12};
    vecs[1] = '{12'hABC, 8'hA5, 8'h03, 1'b0, 5, 0, 12'h3A5, 8'hBC, 8'h0A, 20, 12};
    vecs[2] = '{12'hABC, 8'hA5, 8'h03, 1'b0, 0, 4, 12'h3A5, 8'hBC, 8'h0A, 19, 12};
    vecs[3] = '{12'hABC, 8'hA5, 8'h03, 1'b1, 0, 0, FUNC_D,  8'hBC, 8'h0A, 16, 13};
    vecs[4] = '{12'h5F1, 8'h7E, 8'hFC, 1'b0, 0, 0, 12'hC7E, 8'hF1, 8'h05, 15, 12};

    // Clock/reset
    R = 1'b0;
    repeat (3) @(negedge C);
    #1;
    check_idle_outputs("reset");
    check("reset_cap_data", cap_data, 0);
    @(negedge C);
    R = 1'b1;

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp_c0);
      exp_q.push_back(vecs[i].exp_c1);
      run_op(vecs[i].pre, vecs[i].w0, vecs[i].w1, vecs[i].capq, vecs[i].gap,
             vecs[i].stall, 1'b0, lat, clks, got_n);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_clk_en_cycles", i), clks, vecs[i].exp_clk);
      check($sformatf("vec%0d_chain", i), chain, vecs[i].exp_chain);
      check($sformatf("vec%0d_cap_count", i), got_n, 2);
      exp_q.delete();
    end

    // Abort after five shifts
    chain = 12'h0F0;
    @(negedge C);
    start = 1'b1; load_valid = 1'b1; load_data = 8'h5A; cap_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
      #1;
      if (chain_clk_en) n++;
      @(negedge C);
      start = 1'b0;
    end
    check("abort_shift_count", n, 5);
    abort = 1'b1; load_valid = 1'b0;
    @(negedge C);
    abort = 1'b0;
    #1;
    check_idle_outputs("abort");
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge C);
      #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);

    // Abort beats start in the same cycle
    @(negedge C);
    start = 1'b1; abort = 1'b1;
    @(negedge C);
    start = 1'b0; abort = 1'b0;
    #1;
    check("abort_over_start", busy, 0);

    // A normal operation after abort
    exp_q.push_back(8'hBC);
    exp_q.push_back(8'h0A);
    run_op(12'hABC, 8'hA5, 8'h03, 1'b0, 0, 0, 1'b0, lat, clks, got_n);
    check("restart_latency", lat, 15);
    check("restart_chain", chain, 12'h3A5);
    exp_q.delete();

    // Start while busy, then reset mid-shift
    chain = 12'hFFF;
    @(negedge C);
    start = 1'b1; load_valid = 1'b1; load_data = 8'hA5; cap_ready = 1'b1;
    repeat (11) begin
      @(negedge C);
      start = 1'b0;
    end
    start = 1'b1;
    @(negedge C);
    start = 1'b0;
    #1;
    check("busy_start_ignored_busy", busy, 1);
    check("busy_start_ignored_sc_en", sc_en, 1);
    check("pre_reset_cap_data", cap_data, 8'hFF);
    R = 1'b0; load_valid = 1'b0;
    @(negedge C);
    #1;
    check_idle_outputs("midreset");
    check("midreset_cap_data", cap_data, 0);
    R = 1'b1;

    // Randomized data and handshakes against the stream model
    for (int i = 0; i < 25; i++) begin
      pre  = 12'($urandom);
      w0   = 8'($urandom);
      w1   = 8'($urandom);
      capq = 1'($urandom_range(0, 1));
      exp_q.push_back(8'(pre % 256));
      exp_q.push_back(8'(pre / 256));
      exp_chain = capq ? FUNC_D : 12'({w1, w0} % 4096);
      run_op(pre, w0, w1, capq, 0, 0, 1'b1, lat, clks, got_n);
      check("rnd_latency_min", lat >= CL + 3 + int'(capq), 1);
      check("rnd_clk_en_cycles", clks, CL + int'(capq));
      check("rnd_chain", chain, exp_chain);
      check("rnd_cap_count", got_n, 2);
      exp_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sofa_plus_scan_ctrl.md
# sofa_plus_scan_ctrl

Scan-chain sequencer for a chain of `sofa_plus_dff` cells, whose scan-enable and scan-data pins are shared by every flop in the chain. It accepts host words, serialises them onto the chain scan-in, and packs the chain scan-out into host words on a second stream. The chain flops have no hold mode, so the block drives a clock-enable for the chain's clock gate and stalls without corrupting chain state. It optionally fires one functional capture clock after the shift, then pulses done.

## Interface
- `CHAIN_LEN`, default 64: number of flops in the chain, ≥ 1.
- `WORD_W`, default 8: host word width, ≥ 2.

- `C`  in  1  clock; the block and the gated chain clock share it.
- `R`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a shift; ignored unless idle.
- `capture_req`  in  1  sampled together with `start`; 1 requests a functional capture after the shift.
- `abort`  in  1  return to IDLE at the next edge.
- `load_valid`  in  1  host scan-in word is valid.
- `load_data`  in  WORD_W  scan-in word; bit 0 is shifted first.
- `load_ready`  out  1  block accepts `load_data` this cycle.
- `cap_valid`  out  1  scan-out word is valid.
- `cap_data`  out  WORD_W  scan-out word; bit 0 is the first bit out of the chain.
- `cap_ready`  in  1  host accepts `cap_data`.
- `sc_en`  out  1  drives Test_en of all chain flops.
- `sc_di`  out  1  drives DI of the first chain flop.
- `sc_do`  in  1  Q of the last chain flop.
- `chain_clk_en`  out  1  enable for the chain's clock-gating cell. It is combinational, so it must go through a latch-based ICG.
- `busy`  out  1  high whenever the block is not in IDLE.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, SHIFT, CAPT, DONE.
- Registers:
  - `sreg` (WORD_W bits) and `sbits` (number of bits still held in `sreg`).
  - `rem`, the bits still to shift; starts at CHAIN_LEN.
  - `acc` and `abits`, which collect the scan-out bits.
  - `cap_data` and `cap_valid`.
  - `cap_flag`.
- IDLE → SHIFT when `start`=1. At that edge: `rem`←CHAIN_LEN, `sbits`←0, `abits`←0, `cap_flag`←`capture_req`.
- Shift condition, `shift` = state==SHIFT && `sbits`≠0 && !(`cap_valid` && !`cap_ready`).
- In SHIFT:
  - `sc_en`=1.
  - `sc_di`=`sreg[0]`.
  - `chain_clk_en`=`shift`.
- Load handshake: `load_ready` = state==SHIFT && `rem` > `sbits` && (`sbits`==0 || (`sbits`==1 && `shift`)).
- On load accept: `sreg`←`load_data`, `sbits`←min(WORD_W, `rem` − bits still pending after this cycle's shift). When CHAIN_LEN is not a multiple of WORD_W, the upper bits of the last word are ignored.
- On each `shift` edge:
  - `sreg`>>1, `sbits`−1, `rem`−1.
  - `acc[abits]`←`sc_do`, sampled at the same edge, i.e. the pre-shift tail value. `abits`+1.
- Capture-word emission: when `abits` reaches WORD_W, or when `rem` reaches 0:
  - `cap_data`←`acc`; the upper bits of a partial last word are 0.
  - `cap_valid`←1 and `abits`←0.
  - `cap_valid` clears on `cap_valid` && `cap_ready`. Only one word is ever pending.
- Leaving SHIFT requires `rem`==0 and no pending `cap_valid`:
  - → CAPT if `cap_flag` = 1.
  - → DONE otherwise.
- CAPT lasts one cycle: `sc_en`=0, `chain_clk_en`=1, so the chain loads D. Then → DONE.
- DONE lasts one cycle: `done`=1. Then → IDLE.
- Whenever the state is not SHIFT or CAPT, `sc_en`=0 and `chain_clk_en`=0.
- `abort`:
  - From any state, the next state is IDLE and `cap_valid`←0. No `done` pulse.
  - A partial word held in `acc` is discarded.
  - `abort` takes priority over `start` in the same cycle.
- Reset (`R`=0): state IDLE; all counters 0; `sreg` and `acc` 0; `cap_valid`=0, `done`=0, `busy`=0, `sc_en`=0, `chain_clk_en`=0, `load_ready`=0, `sc_di`=0. Reset mid-shift leaves chain contents undefined; the host restarts.

## Timing
- `start` at edge t puts the block in SHIFT at t+1 with `load_ready`=1.
- The first word is accepted at edge t+1 (if `load_valid`=1), and the first chain shift happens at edge t+2.
- Steady state is one bit per cycle with no bubble between words, provided `load_valid` and `cap_ready` are held high.
- Minimum `start`-to-`done` time with CHAIN_LEN bits and no capture: CHAIN_LEN+3 cycles. Add 1 cycle when a capture is requested.
- A stall on `load_valid`=0 or on a blocked `cap_ready` holds `chain_clk_en`=0. The chain and all counters freeze.
- `busy` = state≠IDLE, registered.

## Test plan
- CHAIN_LEN=12, WORD_W=8, chain model preloaded with 0xABC (tail bit first = bit 0), words 0xA5 then 0x03, `cap_ready`=1 → chain holds 0x3A5, `cap_data` 0xBC then 0x0A, `done` at cycle 15 after `start`, exactly 12 `chain_clk_en` cycles.
- Same setup, `load_valid` dropped for 5 cycles after the first word → 5 cycles with `chain_clk_en`=0, final chain contents identical, `done` 5 cycles later.
- `cap_ready` held low for 4 cycles after the first `cap_valid` → shifting frozen while `cap_valid`=1 && `cap_ready`=0, no lost or duplicated bits.
- `capture_req`=1 with `start` → exactly one cycle with `sc_en`=0 and `chain_clk_en`=1 after the last shift, then `done`.
- `abort` after 5 shifts → IDLE next cycle, `sc_en`/`chain_clk_en`/`cap_valid` go to 0, no `done`. A new `start` then works normally.
- `R`=0 asserted mid-SHIFT, plus `start` while busy → all outputs reach reset values at the next edge; `start` while busy is ignored.
